// File: rtl/fm_out_video_read.sv
// fm_out_video_read
//   Fetches one frame of 30-bit pixels from the frame buffer that the output
//   writer is not using, and queues them in a small FIFO for the panel side.
//   Requests are only raised when there is FIFO space for the data, counting
//   reads that are still in flight, so the FIFO can never overflow.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   frame_alt         buffer the writer is using; this block reads the other one
//   frame_start       one-cycle pulse that (re)starts fetching at pixel 0
//   fm_ov_rd_cycle    arbiter read slot for this port in this cycle
//   fm_cycle_stp_adv  slot cancel; the slot is not counted as issued
//   fm_rd_d           read data {2'b00, R, G, B}, valid 2 cycles after issue
//   pix_rd            panel pops one pixel
//   fm_ov_rd_req      read request to the arbiter
//   fm_ov_rd_adrs     {buffer bit, 18-bit pixel index}
//   red/green/blue    last popped pixel
//   pix_valid         FIFO non-empty
//   underflow         sticky flag: pop attempted on an empty FIFO
module fm_out_video_read #(
   parameter int H_ACT      = 480,
   parameter int V_ACT      = 270,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_alt,
   input  logic        frame_start,
   input  logic        fm_ov_rd_cycle,
   input  logic        fm_cycle_stp_adv,
   input  logic [31:0] fm_rd_d,
   input  logic        pix_rd,
   output logic        fm_ov_rd_req,
   output logic [18:0] fm_ov_rd_adrs,
   output logic [9:0]  red,
   output logic [9:0]  green,
   output logic [9:0]  blue,
   output logic        pix_valid,
   output logic        underflow
);

   localparam int             TOTAL    = H_ACT * V_ACT;
   localparam logic [17:0]    LAST_IDX = 18'(TOTAL - 1);
   localparam int             AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW+1:0]  DEPTH_C  = (AW + 2)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t        state_q, state_d;
   logic          buf_q, buf_d;
   logic [17:0]   idx_q, idx_d;
   logic          rv1_q, rv1_d;   // return due next cycle
   logic          rv2_q, rv2_d;   // return on fm_rd_d this cycle
   logic [1:0]    drop_q, drop_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [29:0]   pix_q, pix_d;
   logic          uf_q, uf_d;
   logic [29:0]   mem_q [FIFO_DEPTH];

   logic          issue, push, pop;
   logic [1:0]    in_flight;
   logic [AW+1:0] credit_sum;
   logic          unused_hi;

   assign unused_hi = ^fm_rd_d[31:30];

   always_comb begin
      in_flight    = {1'b0, rv1_q} + {1'b0, rv2_q};
      credit_sum   = {1'b0, cnt_q} + (AW + 2)'(in_flight);
      fm_ov_rd_req = (state_q == FETCH) && (credit_sum < DEPTH_C);
      issue        = fm_ov_rd_req & fm_ov_rd_cycle & ~fm_cycle_stp_adv;
      // frame_start flushes, so neither a returning word nor a pop may land that cycle
      push         = rv2_q && (drop_q == 2'd0) && !frame_start;
      pop          = pix_rd && (cnt_q != '0) && !frame_start;

      state_d  = state_q;
      buf_d    = buf_q;
      idx_d    = idx_q;
      rv1_d    = issue;
      rv2_d    = rv1_q;
      drop_d   = drop_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      pix_d    = pix_q;
      uf_d     = uf_q;

      if (frame_start) begin
         state_d  = FETCH;
         buf_d    = ~frame_alt;
         idx_d    = '0;
         // the word on fm_rd_d now is suppressed above; what is still in flight
         // after this edge is the older pending read plus any issue made now
         drop_d   = {1'b0, rv1_q} + {1'b0, issue};
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         uf_d     = 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (issue) begin
                  if (idx_q == LAST_IDX) state_d = DONE;
                  else                   idx_d   = idx_q + 18'd1;
               end
            end
            default: ;
         endcase

         if (rv2_q && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            pix_d    = mem_q[rd_ptr_q];
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
         if (pix_rd && (cnt_q == '0)) uf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         buf_q    <= 1'b0;
         idx_q    <= '0;
         rv1_q    <= 1'b0;
         rv2_q    <= 1'b0;
         drop_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         pix_q    <= '0;
         uf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         idx_q    <= idx_d;
         rv1_q    <= rv1_d;
         rv2_q    <= rv2_d;
         drop_q   <= drop_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         pix_q    <= pix_d;
         uf_q     <= uf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= fm_rd_d[29:0];
   end

   assign fm_ov_rd_adrs = {buf_q, idx_q};
   assign red           = pix_q[29:20];
   assign green         = pix_q[19:10];
   assign blue          = pix_q[9:0];
   assign pix_valid     = (cnt_q != '0);
   assign underflow     = uf_q;

endmodule

// File: tb/tb_fm_out_video_read.sv
// Bench for fm_out_video_read: a queue-based model of the fetch/return/FIFO
// behaviour predicts every output each cycle; a memory responder returns
// hashed data two cycles after each issued read.
module tb_fm_out_video_read;
   localparam int H   = 6;
   localparam int V   = 5;
   localparam int D   = 16;
   localparam int TOT = H * V;

   logic        clk = 1'b0;
   logic        rst_n, frame_alt, frame_start, fm_ov_rd_cycle, fm_cycle_stp_adv, pix_rd;
   logic [31:0] fm_rd_d;
   logic        fm_ov_rd_req;
   logic [18:0] fm_ov_rd_adrs;
   logic [9:0]  red, green, blue;
   logic        pix_valid, underflow;

   always #5 clk = ~clk;

   fm_out_video_read #(.H_ACT(H), .V_ACT(V), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .frame_alt(frame_alt), .frame_start(frame_start),
      .fm_ov_rd_cycle(fm_ov_rd_cycle), .fm_cycle_stp_adv(fm_cycle_stp_adv),
      .fm_rd_d(fm_rd_d), .pix_rd(pix_rd), .fm_ov_rd_req(fm_ov_rd_req),
      .fm_ov_rd_adrs(fm_ov_rd_adrs), .red(red), .green(green), .blue(blue),
      .pix_valid(pix_valid), .underflow(underflow));

   int n_chk  = 0;
   int n_fail = 0;
   int cyc_n  = 0;

   typedef struct {logic [18:0] addr; int cyc; bit keep;} pend_t;
   typedef struct {logic [18:0] addr; int cyc;} rsp_t;
   pend_t       pend[$];   // reads issued, data not yet returned
   logic [29:0] fifo[$];
   rsp_t        rsp[$];    // memory-side view of issued reads
   bit          m_fetch;
   logic        m_buf;
   int          m_idx;
   logic [29:0] m_pix;
   bit          m_uf;

   function automatic logic [29:0] mem_val(input logic [18:0] a);
      logic [31:0] h;
      h = {13'b0, a} * 32'h9E3779B1;
      h = h ^ (h >> 15);
      return h[29:0];
   endfunction

   function automatic bit m_req();
      return m_fetch && ((fifo.size() + pend.size()) < D);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      fifo.delete();
      m_fetch = 0;
      m_buf   = 1'b0;
      m_idx   = 0;
      m_pix   = '0;
      m_uf    = 0;
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic step(input bit fs, input bit alt, input bit cy, input bit st,
                       input bit pr, input bit rn);
      bit          iss, arr, arr_keep;
      logic [18:0] arr_addr;
      chk("req",       32'(fm_ov_rd_req),  32'(m_req()));
      chk("adrs",      32'(fm_ov_rd_adrs), 32'({m_buf, 18'(m_idx)}));
      chk("pix_valid", 32'(pix_valid),     32'(fifo.size() > 0));
      chk("rgb",       32'({red, green, blue}), 32'(m_pix));
      chk("underflow", 32'(underflow),     32'(m_uf));

      rst_n = rn; frame_start = fs; frame_alt = alt;
      fm_ov_rd_cycle = cy; fm_cycle_stp_adv = st; pix_rd = pr;
      fm_rd_d = $urandom();
      if (rsp.size() > 0 && rsp[0].cyc == cyc_n - 2) begin
         fm_rd_d = {2'b00, mem_val(rsp[0].addr)};
         void'(rsp.pop_front());
      end
      if (fm_ov_rd_req && cy && !st) rsp.push_back('{fm_ov_rd_adrs, cyc_n});

      iss      = m_req() && cy && !st;
      arr      = (pend.size() > 0) && (pend[0].cyc == cyc_n - 2);
      arr_keep = 0;
      arr_addr = '0;
      if (arr) begin
         arr_keep = pend[0].keep;
         arr_addr = pend[0].addr;
         void'(pend.pop_front());
      end
      if (!rn) begin
         model_reset();
      end else if (fs) begin
         fifo.delete();
         foreach (pend[i]) pend[i].keep = 0;
         if (iss) pend.push_back('{{m_buf, 18'(m_idx)}, cyc_n, 1'b0});
         m_fetch = 1; m_buf = ~alt; m_idx = 0; m_uf = 0;
      end else begin
         if (pr) begin
            if (fifo.size() > 0) m_pix = fifo.pop_front();
            else                 m_uf  = 1;
         end
         if (arr && arr_keep) fifo.push_back(mem_val(arr_addr));
         if (iss) begin
            pend.push_back('{{m_buf, 18'(m_idx)}, cyc_n, 1'b1});
            if (m_idx == TOT - 1) m_fetch = 0;
            else                  m_idx++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc_n++;
   endtask

   initial begin
      rst_n = 1'b0; frame_alt = 1'b0; frame_start = 1'b0; fm_ov_rd_cycle = 1'b1;
      fm_cycle_stp_adv = 1'b0; pix_rd = 1'b0; fm_rd_d = '0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      cyc_n = 1;

      // reset state
      step(0, 0, 1, 0, 0, 0);
      chk("rst_req",   32'(fm_ov_rd_req),  32'h0);
      chk("rst_adrs",  32'(fm_ov_rd_adrs), 32'h0);
      chk("rst_valid", 32'(pix_valid),     32'h0);
      chk("rst_uf",    32'(underflow),     32'h0);

      // start frame on buffer 1, prefill with one cancelled slot at index 5
      step(1, 0, 1, 0, 0, 1);
      chk("start_req",  32'(fm_ov_rd_req),  32'h1);
      chk("start_adrs", 32'(fm_ov_rd_adrs), 32'h40000);
      for (int i = 0; i < 25; i++) begin
         step(0, 0, 1, (i == 5), 0, 1);
         if (i == 1) chk("valid_lat2", 32'(pix_valid), 32'h0);
         if (i == 2) chk("valid_lat3", 32'(pix_valid), 32'h1);
         if (i == 5) chk("cancel_hold", 32'(fm_ov_rd_adrs), 32'h40005);
         if (i == 6) chk("cancel_reissue", 32'(fm_ov_rd_adrs), 32'h40006);
      end
      chk("credit_req",  32'(fm_ov_rd_req),  32'h0);
      chk("credit_adrs", 32'(fm_ov_rd_adrs), 32'h40010);

      // drain the whole frame, popping only while valid
      for (int i = 0; i < 60; i++) step(0, 0, 1, 0, pix_valid, 1);
      chk("done_req",   32'(fm_ov_rd_req),  32'h0);
      chk("done_adrs",  32'(fm_ov_rd_adrs), 32'h4001D);
      chk("done_valid", 32'(pix_valid),     32'h0);
      chk("done_uf",    32'(underflow),     32'h0);
      chk("last_pix",   32'({red, green, blue}), 32'(mem_val(19'h4001D)));

      // pop on empty FIFO
      step(0, 0, 1, 0, 1, 1);
      chk("uf_set",  32'(underflow), 32'h1);
      chk("uf_hold", 32'({red, green, blue}), 32'(mem_val(19'h4001D)));
      step(1, 0, 1, 0, 0, 1);
      chk("uf_clear", 32'(underflow), 32'h0);

      // restart with reads in flight, now on buffer 0
      step(0, 0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 0, 1);
      step(1, 1, 1, 0, 1, 1);
      chk("restart_adrs",  32'(fm_ov_rd_adrs), 32'h00000);
      chk("restart_valid", 32'(pix_valid),     32'h0);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, 1);
      step(0, 1, 1, 0, 1, 1);
      chk("restart_pix0", 32'({red, green, blue}), 32'(mem_val(19'h00000)));

      // reset mid-fetch with returns pending
      step(0, 1, 1, 0, 1, 1);
      step(0, 1, 1, 0, 1, 0);
      chk("mid_rst_req",   32'(fm_ov_rd_req),  32'h0);
      chk("mid_rst_adrs",  32'(fm_ov_rd_adrs), 32'h0);
      chk("mid_rst_valid", 32'(pix_valid),     32'h0);
      chk("mid_rst_rgb",   32'({red, green, blue}), 32'h0);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 1);
      chk("late_ret", 32'(pix_valid), 32'h0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) < 2), ($urandom_range(0, 599) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
